ahfp_cordic_vector_fixed: RTL and testbench
===========================================

# ahfp_cordic_vector_fixed

Iterative vectoring-mode CORDIC: the inverse of the rotation-mode cosine unit. Given a fixed-point vector (x, y), it produces the angle atan2(y, x) and the gain-scaled magnitude, reusing the same Q3.29 angle format, arctangent table and CORDIC gain. It is one shared datapath, doing one micro-rotation per clock under a start/busy/done handshake. It sits downstream of arithmetic that needs angle recovery, such as polar conversion or phase detection.

## Interface
- N, 10, number of micro-rotations; legal range 1..10.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- x_in  input  32  signed Q3.29 x component; |x_in| <= 1.0 (0x20000000).
- y_in  input  32  signed Q3.29 y component; |y_in| <= 1.0.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; results valid from this cycle onward.
- theta_out  output  32  signed Q3.29 radians, range [-pi, +pi].
- mag_out  output  32  unsigned Q3.29, equal to K*sqrt(x²+y²), where K = 1/0x136e9e80 ≈ 1.64676 (N=10). Not gain-compensated.

## Operation
- The arctangent table holds atan(2^-i) in Q3.29 for i = 0..9:
  - 1921fb60, 0ed63380, 07d6dd80, 03fab754, 01ff55bc
  - 00ffeaae, 007ffd55, 003fffaa, 001ffff5, 000ffffe
- Constants: pi/2 = 0x3243F6A8, -pi/2 = 0xCDBC0958.
- Internal x, y and z registers are 32-bit signed. Shifts are arithmetic (>>>). Add/sub wraps mod 2^32; the input range guarantees no overflow (|x| max ≈ 2.33 < 4).
- States and transitions:
  - IDLE, start=1: latch inputs with pre-rotation, set iter=0, go to ITER.
  - ITER: perform iteration iter. If iter == N-1, register results and go to DONE; otherwise increment iter.
  - DONE: done=1. With start=1, load new operands and go to ITER; otherwise go to IDLE.
- Pre-rotation on load:
  - x_in >= 0: x=x_in, y=y_in, z=0.
  - x_in < 0 and y_in >= 0: x=y_in, y=-x_in, z=+pi/2.
  - x_in < 0 and y_in < 0: x=-y_in, y=x_in, z=-pi/2.
- Iteration i:
  - y >= 0 (sign bit 0): x += y>>>i, y -= x>>>i, z += atan[i].
  - y < 0: x -= y>>>i, y += x>>>i, z -= atan[i].
  - All updates use old values.
- Results: theta_out <= z, mag_out <= x.
- Zero vector (x_in = y_in = 0): a zero flag is latched at load. On entering DONE, theta_out = 0 and mag_out = 0. Latency is the same as for any other vector.
- Ignored start: start is ignored in ITER. Operands are captured only at the load edge, so later input changes have no effect.
- Held results: theta_out and mag_out change only on the edge entering DONE, and hold until the next DONE.

## Timing
- Reset values: busy=0, done=0, theta_out=0, mag_out=0, state=IDLE, iter=0, internal x/y/z=0.
- Reset asserted mid-operation aborts immediately. No done pulse occurs, outputs return to 0, and start is next honoured after rst deasserts.
- Load edge E0: busy=1 after E0.
- done=1 during the cycle after edge E0+N, for exactly one cycle.
- New operation: start=1 in that DONE cycle begins a new operation at edge E0+N+1. Throughput is therefore one result per N+1 cycles, with busy held high between the two operations.
- Without a new start, busy falls after edge E0+N+1.
- done never asserts in two consecutive cycles.

## Test plan
- (1) x=0x10000000, y=0 → exactly N+1 cycles from the start edge to done; |theta_out| < 0x00100000; mag_out ≈ 0x1A591D1C ±0.5%.
- (2) x=y=0x10000000 → theta_out ≈ 0x1921FB54 ±0x00100000; mag_out ≈ 1.1644 (Q3.29) ±0.5%.
- (3) Quadrant sweep, with results checked against a real-valued atan2 model, tolerance 2^20 LSB:
  - x=0xF0000000 (-0.5), y=0 → theta_out ≈ 0x6487ED51.
  - x=0, y=0xF0000000 → theta_out ≈ 0xCDBC0958.
  - x=y=-0.5 → theta_out ≈ -3pi/4.
- (4) x=y=0 → done after N+1 cycles with theta_out=0 and mag_out=0.
- (5) Handshake:
  - Pulse start again mid-ITER and change x_in/y_in → ignored; the first result is unchanged.
  - Hold start high through DONE → the second operation loads immediately and done pulses exactly N+1 cycles apart.
- (6) Assert rst at iteration 4 → busy, done and the outputs are 0 asynchronously. No done pulse follows. A fresh start after release produces a correct result.

Source files
------------

// File: rtl/ahfp_cordic_vector_fixed_if.sv
// Handshake and operand/result bundle for the vectoring CORDIC.
// The master drives start and the operands. The slave returns the status and the results.
interface ahfp_cordic_vector_fixed_if;
    logic               start;
    logic signed [31:0] x_in;
    logic signed [31:0] y_in;
    logic               busy;
    logic               done;
    logic signed [31:0] theta_out;
    logic        [31:0] mag_out;

    modport master (
        output start, x_in, y_in,
        input  busy, done, theta_out, mag_out
    );

    modport slave (
        input  start, x_in, y_in,
        output busy, done, theta_out, mag_out
    );
endinterface

// File: rtl/ahfp_cordic_vector_fixed.sv
// Iterative vectoring-mode CORDIC that performs one micro-rotation per clock.
// It returns atan2(y, x) and the gain-scaled magnitude, both in Q3.29.
module ahfp_cordic_vector_fixed #(
    parameter int N = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    ahfp_cordic_vector_fixed_if.slave   bus
);

    localparam logic signed [31:0] HALF_PI = 32'sh3243F6A8;

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t             state;
    state_t             state_next;
    logic [3:0]         iter;
    logic signed [31:0] x;
    logic signed [31:0] y;
    logic signed [31:0] z;
    logic signed [31:0] x_step;
    logic signed [31:0] y_step;
    logic signed [31:0] z_step;
    logic signed [31:0] atan_i;
    logic               zero_vec;
    logic               load;
    logic               last;

    assign load = ((state == IDLE) || (state == DONE)) && bus.start;
    assign last = (iter == 4'(N - 1));

    always_comb begin
        atan_i = '0;
        case (iter)
            4'd0:    atan_i = 32'sh1921fb60;
            4'd1:    atan_i = 32'sh0ed63380;
            4'd2:    atan_i = 32'sh07d6dd80;
            4'd3:    atan_i = 32'sh03fab754;
            4'd4:    atan_i = 32'sh01ff55bc;
            4'd5:    atan_i = 32'sh00ffeaae;
            4'd6:    atan_i = 32'sh007ffd55;
            4'd7:    atan_i = 32'sh003fffaa;
            4'd8:    atan_i = 32'sh001ffff5;
            4'd9:    atan_i = 32'sh000ffffe;
            default: atan_i = '0;
        endcase
    end

    // Each micro-rotation drives y toward zero and accumulates the applied angle in z.
    always_comb begin
        if (!y[31]) begin
            x_step = x + (y >>> iter);
            y_step = y - (x >>> iter);
            z_step = z + atan_i;
        end else begin
            x_step = x - (y >>> iter);
            y_step = y + (x >>> iter);
            z_step = z - atan_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = ITER;
            ITER:    if (last) state_next = DONE;
            DONE:    state_next = bus.start ? ITER : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state != IDLE);
        bus.done = (state == DONE);
    end

    // The load pre-rotation folds the left half-plane into the convergence range of +/-1.74 rad.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iter          <= '0;
            x             <= '0;
            y             <= '0;
            z             <= '0;
            zero_vec      <= 1'b0;
            bus.theta_out <= '0;
            bus.mag_out   <= '0;
        end else if (load) begin
            iter     <= '0;
            zero_vec <= (bus.x_in == '0) && (bus.y_in == '0);
            if (!bus.x_in[31]) begin
                x <= bus.x_in;
                y <= bus.y_in;
                z <= '0;
            end else if (!bus.y_in[31]) begin
                x <= bus.y_in;
                y <= -bus.x_in;
                z <= HALF_PI;
            end else begin
                x <= -bus.y_in;
                y <= bus.x_in;
                z <= -HALF_PI;
            end
        end else if (state == ITER) begin
            x <= x_step;
            y <= y_step;
            z <= z_step;
            if (last) begin
                bus.theta_out <= zero_vec ? '0 : z_step;
                bus.mag_out   <= zero_vec ? '0 : x_step;
            end else begin
                iter <= iter + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_ahfp_cordic_vector_fixed.sv
// Randomized self-checking bench for the vectoring CORDIC.
// A schedule of expected results is compared every cycle, with real-valued atan2 sanity checks.
module tb_ahfp_cordic_vector_fixed;

    localparam int  N      = 10;
    localparam real SCALE  = 536870912.0;
    localparam real PI     = 3.14159265358979323846;
    localparam int  HALF_PI = 32'h3243F6A8;
    localparam int  ATAN [10] = '{32'h1921fb60, 32'h0ed63380, 32'h07d6dd80, 32'h03fab754,
                                  32'h01ff55bc, 32'h00ffeaae, 32'h007ffd55, 32'h003fffaa,
                                  32'h001ffff5, 32'h000ffffe};

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    int     wr = 0;
    int     rd = 0;
    int     op_e0   [256];
    int     op_th   [256];
    int     op_mg   [256];
    int     op_x    [256];
    int     op_y    [256];
    bit     op_pin  [256];
    longint op_pth  [256];
    longint op_ptol [256];
    longint op_pmg  [256];
    longint op_pmtol[256];
    longint held_th = 0;
    longint held_mg = 0;

    ahfp_cordic_vector_fixed_if bus();

    ahfp_cordic_vector_fixed #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Reference CORDIC written as a plain loop over the arithmetic rules.
    function automatic void model(input int xi, input int yi, output int th, output int mg);
        int xv, yv, zv, xn;
        if (xi == 0 && yi == 0) begin
            th = 0;
            mg = 0;
            return;
        end
        if (xi >= 0) begin
            xv = xi;  yv = yi;  zv = 0;
        end else if (yi >= 0) begin
            xv = yi;  yv = -xi; zv = HALF_PI;
        end else begin
            xv = -yi; yv = xi;  zv = -HALF_PI;
        end
        for (int i = 0; i < N; i++) begin
            if (yv >= 0) begin
                xn = xv + (yv >>> i);
                yv = yv - (xv >>> i);
                zv = zv + ATAN[i];
            end else begin
                xn = xv - (yv >>> i);
                yv = yv + (xv >>> i);
                zv = zv - ATAN[i];
            end
            xv = xn;
        end
        th = zv;
        mg = xv;
    endfunction

    function automatic real ang_err(input real a, input real b);
        real d;
        d = a - b;
        while (d > PI) d = d - 2.0 * PI;
        while (d < -PI) d = d + 2.0 * PI;
        return (d < 0.0) ? -d : d;
    endfunction

    task automatic check_output(input string name, input longint got, input longint exp, input longint tol);
        longint diff;
        n_cmp = n_cmp + 1;
        diff = got - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            n_bad = n_bad + 1;
            $display("[TB] FAIL %s: got %0d required %0d (tol %0d) at cycle %0d", name, got, exp, tol, cyc);
        end
    endtask

    // Per-cycle comparison against the expected-result schedule; reset forces everything to zero.
    always @(negedge clk or posedge rst) begin
        int     s;
        bit     active;
        bit     exp_done;
        longint th_got;
        longint mg_got;
        real    rx, ry, r, kg;
        if (rst) begin
            #1;
            check_output("rst_busy",  longint'(bus.busy), 0, 0);
            check_output("rst_done",  longint'(bus.done), 0, 0);
            check_output("rst_theta", longint'(bus.theta_out), 0, 0);
            check_output("rst_mag",   longint'(bus.mag_out), 0, 0);
            rd = wr;
            held_th = 0;
            held_mg = 0;
        end else begin
            s        = rd & 255;
            active   = (rd != wr) && (op_e0[s] <= cyc);
            exp_done = active && (cyc == op_e0[s] + N);
            th_got   = longint'(bus.theta_out);
            mg_got   = longint'(bus.mag_out);
            check_output("busy", longint'(bus.busy), longint'(active), 0);
            check_output("done", longint'(bus.done), longint'(exp_done), 0);
            if (exp_done) begin
                check_output("theta", th_got, longint'(op_th[s]), 0);
                check_output("mag",   mg_got, longint'(op_mg[s]), 0);
                if (op_pin[s]) begin
                    check_output("pin_theta", th_got, op_pth[s], op_ptol[s]);
                    check_output("pin_mag",   mg_got, op_pmg[s], op_pmtol[s]);
                end
                rx = real'(op_x[s]);
                ry = real'(op_y[s]);
                r  = $sqrt(rx * rx + ry * ry);
                if (r >= 4194304.0) begin
                    kg = SCALE / real'(32'h136e9e80);
                    check_output("real_theta", longint'(ang_err(real'(th_got) / SCALE, $atan2(ry, rx)) * SCALE),
                                 0, 2097152);
                    check_output("real_mag", mg_got, longint'(kg * r), longint'(kg * r * 0.005) + 64);
                end
                held_th = longint'(op_th[s]);
                held_mg = longint'(op_mg[s]);
                rd = rd + 1;
            end else begin
                check_output("theta_hold", th_got, held_th, 0);
                check_output("mag_hold",   mg_got, held_mg, 0);
            end
        end
    end

    task automatic push_op(input int xv, input int yv, input bit pin,
                           input longint pth, input longint ptol, input longint pmg, input longint pmtol);
        int s, th, mg;
        model(xv, yv, th, mg);
        s = wr & 255;
        op_e0[s]    = cyc + 1;
        op_th[s]    = th;
        op_mg[s]    = mg;
        op_x[s]     = xv;
        op_y[s]     = yv;
        op_pin[s]   = pin;
        op_pth[s]   = pth;
        op_ptol[s]  = ptol;
        op_pmg[s]   = pmg;
        op_pmtol[s] = pmtol;
        wr = wr + 1;
    endtask

    // Called at a negedge; returns at the negedge of the done cycle with start low.
    task automatic apply_stimulus(input int xv, input int yv, input bit hold, input bit poke, input bit pin,
                                  input longint pth, input longint ptol, input longint pmg, input longint pmtol);
        bus.start = 1'b1;
        bus.x_in  = xv;
        bus.y_in  = yv;
        push_op(xv, yv, pin, pth, ptol, pmg, pmtol);
        for (int k = 1; k <= N + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (!hold) bus.start = 1'b0;
                bus.x_in = $urandom;
                bus.y_in = $urandom;
            end
            if (poke && k == 3) begin
                bus.start = 1'b1;
                bus.x_in  = $urandom;
                bus.y_in  = $urandom;
            end
            if (poke && k == 4 && !hold) bus.start = 1'b0;
        end
        bus.start = 1'b0;
    endtask

    function automatic int rand_q();
        case ($urandom_range(0, 7))
            0:       return 0;
            1:       return 32'h20000000;
            2:       return -32'sh20000000;
            3:       return int'($urandom_range(0, 255)) - 128;
            default: return int'($urandom_range(0, 32'h40000000)) - 32'h20000000;
        endcase
    endfunction

    initial begin
        longint m_half, m_diag;
        int     xr, yr;
        m_half = 64'h1A591D1C;
        m_diag = longint'(1.1644 * SCALE);
        rst = 1'b1;
        bus.start = 1'b0;
        bus.x_in  = '0;
        bus.y_in  = '0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        $display("[TB] directed vectors");
        apply_stimulus(32'h10000000, 0, 1'b0, 1'b1, 1'b1, 0, 64'h0FFFFF, m_half, m_half / 200);
        apply_stimulus(32'h10000000, 32'h10000000, 1'b0, 1'b0, 1'b1,
                       64'h1921FB54, 64'h100000, m_diag, m_diag / 200);
        repeat (2) @(negedge clk);
        apply_stimulus(32'hF0000000, 0, 1'b0, 1'b0, 1'b1, 64'h6487ED51, 64'h100000, m_half, m_half / 200);
        apply_stimulus(0, 32'hF0000000, 1'b0, 1'b0, 1'b1,
                       longint'(int'(32'hCDBC0958)), 64'h100000, m_half, m_half / 200);
        apply_stimulus(32'hF0000000, 32'hF0000000, 1'b0, 1'b0, 1'b1,
                       longint'(-0.75 * PI * SCALE), 64'h100000, m_diag, m_diag / 200);
        apply_stimulus(0, 0, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0);
        apply_stimulus(32'h10000000, 0, 1'b1, 1'b0, 1'b1, 0, 64'h0FFFFF, m_half, m_half / 200);
        repeat (3) @(negedge clk);

        $display("[TB] reset during iteration 4");
        bus.start = 1'b1;
        bus.x_in  = 32'h0C000000;
        bus.y_in  = 32'hF5000000;
        push_op(32'h0C000000, 32'hF5000000, 1'b0, 0, 0, 0, 0);
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        repeat (N + 3) @(negedge clk);
        apply_stimulus(32'h10000000, 32'h10000000, 1'b0, 1'b0, 1'b1,
                       64'h1921FB54, 64'h100000, m_diag, m_diag / 200);

        $display("[TB] randomized vectors");
        for (int n = 0; n < 80; n++) begin
            xr = rand_q();
            yr = rand_q();
            apply_stimulus(xr, yr, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), 1'b0, 0, 0, 0, 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
